// File: rtl/control_unit.sv
// Multi-cycle control FSM for an accumulator CPU: FETCH/DECODE/MEMRD/STORE/EXEC/HALT.
// Outputs are decoded from the state register, the opcode latched in DECODE, and mem_ready/flags.
module control_unit #(
  parameter int DATA_WIDTH   = 11,
  parameter int OPCODE_WIDTH = 5
) (
  input  logic                    clock,
  input  logic                    reset_n,
  input  logic [OPCODE_WIDTH-1:0] opcode,
  input  logic                    mem_ready,
  input  logic                    zero_flag,
  input  logic                    neg_flag,
  output logic                    ir_wr,
  output logic                    pc_wr,
  output logic                    pc_src,
  output logic                    mem_rd,
  output logic                    mem_wr,
  output logic                    addr_sel,
  output logic                    acc_wr,
  output logic                    acc_clr,
  output logic [1:0]              alu_op,
  output logic                    alu_b_sel,
  output logic                    halted,
  output logic [2:0]              state_out
);

  // The instruction word is opcode followed by a 6-bit operand.
  if (DATA_WIDTH != OPCODE_WIDTH + 6) begin : g_width_check
    $error("control_unit: DATA_WIDTH must equal OPCODE_WIDTH + 6");
  end

  typedef enum logic [2:0] {
    S_FETCH  = 3'd0,
    S_DECODE = 3'd1,
    S_MEMRD  = 3'd2,
    S_STORE  = 3'd3,
    S_EXEC   = 3'd4,
    S_HALT   = 3'd5
  } state_t;

  localparam logic [OPCODE_WIDTH-1:0] OP_HLT  = OPCODE_WIDTH'(0);
  localparam logic [OPCODE_WIDTH-1:0] OP_STO  = OPCODE_WIDTH'(1);
  localparam logic [OPCODE_WIDTH-1:0] OP_LD   = OPCODE_WIDTH'(2);
  localparam logic [OPCODE_WIDTH-1:0] OP_LDI  = OPCODE_WIDTH'(3);
  localparam logic [OPCODE_WIDTH-1:0] OP_ADD  = OPCODE_WIDTH'(4);
  localparam logic [OPCODE_WIDTH-1:0] OP_ADDI = OPCODE_WIDTH'(5);
  localparam logic [OPCODE_WIDTH-1:0] OP_SUB  = OPCODE_WIDTH'(6);
  localparam logic [OPCODE_WIDTH-1:0] OP_SUBI = OPCODE_WIDTH'(7);
  localparam logic [OPCODE_WIDTH-1:0] OP_BEQ  = OPCODE_WIDTH'(8);
  localparam logic [OPCODE_WIDTH-1:0] OP_BNE  = OPCODE_WIDTH'(9);
  localparam logic [OPCODE_WIDTH-1:0] OP_BLT  = OPCODE_WIDTH'(10);
  localparam logic [OPCODE_WIDTH-1:0] OP_JMP  = OPCODE_WIDTH'(11);
  localparam logic [OPCODE_WIDTH-1:0] OP_CLR  = OPCODE_WIDTH'(12);

  state_t                  state_q, state_d;
  logic [OPCODE_WIDTH-1:0] opcode_q, opcode_d;

  always_ff @(posedge clock) begin
    if (!reset_n) begin
      state_q  <= S_FETCH;
      opcode_q <= '0;
    end else begin
      state_q  <= state_d;
      opcode_q <= opcode_d;
    end
  end

  // Memory handshake: mem_rd/mem_wr and addr_sel are held steady while in
  // FETCH/MEMRD/STORE; the access completes in the cycle mem_ready=1, and the
  // FSM leaves that state on the following edge.
  always_comb begin
    state_d   = state_q;
    opcode_d  = opcode_q;
    ir_wr     = 1'b0;
    pc_wr     = 1'b0;
    pc_src    = 1'b0;
    mem_rd    = 1'b0;
    mem_wr    = 1'b0;
    addr_sel  = 1'b0;
    acc_wr    = 1'b0;
    acc_clr   = 1'b0;
    alu_op    = 2'b00;
    alu_b_sel = 1'b0;
    halted    = 1'b0;

    case (state_q)
      S_FETCH: begin
        mem_rd = 1'b1;
        if (mem_ready) begin
          ir_wr   = 1'b1;
          pc_wr   = 1'b1;
          state_d = S_DECODE;
        end
      end
      S_DECODE: begin
        opcode_d = opcode;
        case (opcode)
          OP_HLT:                  state_d = S_HALT;
          OP_LD, OP_ADD, OP_SUB:   state_d = S_MEMRD;
          OP_STO:                  state_d = S_STORE;
          OP_LDI, OP_ADDI, OP_SUBI, OP_CLR,
          OP_BEQ, OP_BNE, OP_BLT, OP_JMP:
                                   state_d = S_EXEC;
          default:                 state_d = S_FETCH;
        endcase
      end
      S_MEMRD: begin
        mem_rd   = 1'b1;
        addr_sel = 1'b1;
        if (mem_ready) state_d = S_EXEC;
      end
      S_STORE: begin
        mem_wr   = 1'b1;
        addr_sel = 1'b1;
        if (mem_ready) state_d = S_FETCH;
      end
      S_EXEC: begin
        state_d = S_FETCH;
        case (opcode_q)
          OP_LD:   acc_wr = 1'b1;
          OP_LDI:  begin acc_wr = 1'b1; alu_b_sel = 1'b1; end
          OP_ADD:  begin acc_wr = 1'b1; alu_op = 2'b01; end
          OP_ADDI: begin acc_wr = 1'b1; alu_op = 2'b01; alu_b_sel = 1'b1; end
          OP_SUB:  begin acc_wr = 1'b1; alu_op = 2'b10; end
          OP_SUBI: begin acc_wr = 1'b1; alu_op = 2'b10; alu_b_sel = 1'b1; end
          OP_CLR:  acc_clr = 1'b1;
          OP_JMP:  begin pc_wr = 1'b1; pc_src = 1'b1; end
          OP_BEQ:  begin pc_wr = zero_flag;  pc_src = zero_flag;  end
          OP_BNE:  begin pc_wr = !zero_flag; pc_src = !zero_flag; end
          OP_BLT:  begin pc_wr = neg_flag;   pc_src = neg_flag;   end
          default: ;
        endcase
      end
      S_HALT:  halted  = 1'b1;
      default: state_d = S_FETCH;
    endcase

    // Register-updating strobes must never fire while reset is held.
    if (!reset_n) begin
      ir_wr   = 1'b0;
      pc_wr   = 1'b0;
      acc_wr  = 1'b0;
      acc_clr = 1'b0;
      mem_wr  = 1'b0;
    end
  end

  assign state_out = state_q;

endmodule

// File: tb/tb_control_unit.sv
// Bench for control_unit: per-instruction expected cycle traces built from the
// instruction-level behaviour, replayed cycle by cycle against the DUT outputs.
module tb_control_unit;

  // ---------------- clock / reset ----------------
  logic clock = 1'b0;
  always #5 clock = ~clock;

  logic       reset_n   = 1'b0;
  logic [4:0] opcode    = '0;
  logic       mem_ready = 1'b0;
  logic       zero_flag = 1'b0;
  logic       neg_flag  = 1'b0;
  logic       ir_wr, pc_wr, pc_src, mem_rd, mem_wr, addr_sel, acc_wr, acc_clr;
  logic [1:0] alu_op;
  logic       alu_b_sel, halted;
  logic [2:0] state_out;

  control_unit #(.DATA_WIDTH(11), .OPCODE_WIDTH(5)) dut (
    .clock(clock), .reset_n(reset_n), .opcode(opcode), .mem_ready(mem_ready),
    .zero_flag(zero_flag), .neg_flag(neg_flag), .ir_wr(ir_wr), .pc_wr(pc_wr),
    .pc_src(pc_src), .mem_rd(mem_rd), .mem_wr(mem_wr), .addr_sel(addr_sel),
    .acc_wr(acc_wr), .acc_clr(acc_clr), .alu_op(alu_op), .alu_b_sel(alu_b_sel),
    .halted(halted), .state_out(state_out)
  );

  // Output vector: {ir,pcw,pcs,rd,wr,as,aw,ac,aop[1:0],bs,h,st[2:0]}
  localparam int W = 15;
  localparam logic [W-1:0] RST_MASK = (15'd1 << 14) | (15'd1 << 13) | (15'd1 << 10)
                                    | (15'd1 << 8) | (15'd1 << 7);

  typedef struct packed {
    logic       rst_n;
    logic       rdy;
    logic       zf;
    logic       nf;
    logic [4:0] op;
  } stim_t;

  // ---------------- scoreboard ----------------
  stim_t          stim_q[$];
  logic [W-1:0]   exp_q[$];
  int             checks   = 0;
  int             failures = 0;
  int             cyc      = 0;

  function automatic logic [W-1:0] pk(input logic ir, pcw, pcs, rd, wr, as, aw, ac,
                                      input logic [1:0] aop, input logic bs, h,
                                      input logic [2:0] st);
    return {ir, pcw, pcs, rd, wr, as, aw, ac, aop, bs, h, st};
  endfunction

  function automatic logic [W-1:0] observed();
    return {ir_wr, pc_wr, pc_src, mem_rd, mem_wr, addr_sel, acc_wr, acc_clr,
            alu_op, alu_b_sel, halted, state_out};
  endfunction

  function automatic stim_t rs(input logic rdy);
    stim_t s;
    s.rst_n = 1'b1;
    s.rdy   = rdy;
    s.zf    = 1'($urandom_range(0, 1));
    s.nf    = 1'($urandom_range(0, 1));
    s.op    = 5'($urandom_range(0, 31));
    return s;
  endfunction

  task automatic check(input string tag, input logic [W-1:0] exp);
    logic [W-1:0] obs;
    obs = observed();
    checks++;
    assert (obs === exp)
    else begin
      failures++;
      $error("FAIL %s cyc=%0d observed=%b required=%b", tag, cyc, obs, exp);
    end
  endtask

  // ---------------- reference model ----------------
  // Expected cycle trace of one instruction. fstall/mstall = stalled cycles in
  // FETCH and in the data access (or HALT dwell for HLT). reset_at >= 0 pulls
  // reset_n low in that cycle of the trace and drops the rest.
  task automatic add_instr(input logic [4:0] op, input int fstall, input int mstall,
                           input logic zf, input logic nf, input int reset_at);
    stim_t        ts[$];
    logic [W-1:0] te[$];
    stim_t        s;
    bit           is_mem, is_exec, is_aw, is_bs, taken;
    logic [1:0]   aop;
    is_mem  = (op == 2 || op == 4 || op == 6);
    is_exec = is_mem || (op >= 3 && op <= 12 && op != 4 && op != 6);
    for (int i = 0; i < fstall; i++) begin
      ts.push_back(rs(1'b0)); te.push_back(pk(0,0,0,1,0,0,0,0,2'b00,0,0,3'd0));
    end
    ts.push_back(rs(1'b1)); te.push_back(pk(1,1,0,1,0,0,0,0,2'b00,0,0,3'd0));
    s = rs(1'($urandom_range(0, 1))); s.op = op;
    ts.push_back(s); te.push_back(pk(0,0,0,0,0,0,0,0,2'b00,0,0,3'd1));
    if (is_mem || op == 1) begin
      for (int i = 0; i <= mstall; i++) begin
        ts.push_back(rs(i == mstall));
        if (op == 1) te.push_back(pk(0,0,0,0,1,1,0,0,2'b00,0,0,3'd3));
        else         te.push_back(pk(0,0,0,1,0,1,0,0,2'b00,0,0,3'd2));
      end
    end
    if (is_exec) begin
      is_aw = (op >= 2 && op <= 7);
      is_bs = (op == 3 || op == 5 || op == 7);
      aop   = (op == 4 || op == 5) ? 2'b01 : (op == 6 || op == 7) ? 2'b10 : 2'b00;
      taken = (op == 11) || (op == 8 && zf) || (op == 9 && !zf) || (op == 10 && nf);
      s = rs(1'($urandom_range(0, 1))); s.zf = zf; s.nf = nf;
      ts.push_back(s);
      te.push_back(pk(0, taken, taken, 0, 0, 0, is_aw, op == 12, aop, is_bs, 0, 3'd4));
    end
    if (op == 0) begin
      for (int i = 0; i <= mstall; i++) begin
        s = rs(1'($urandom_range(0, 1)));
        if (i == mstall) s.rst_n = 1'b0;
        ts.push_back(s); te.push_back(pk(0,0,0,0,0,0,0,0,2'b00,0,1,3'd5));
      end
    end
    for (int i = 0; i < ts.size(); i++) begin
      s = ts[i];
      if (i == reset_at) s.rst_n = 1'b0;
      stim_q.push_back(s);
      exp_q.push_back(s.rst_n ? te[i] : (te[i] & ~RST_MASK));
      if (i == reset_at) break;
    end
  endtask

  // ---------------- driver ----------------
  task automatic run_queue(input string tag);
    stim_t        s;
    logic [W-1:0] e;
    while (exp_q.size() > 0) begin
      @(negedge clock);
      s = stim_q.pop_front();
      e = exp_q.pop_front();
      reset_n   = s.rst_n;
      mem_ready = s.rdy;
      zero_flag = s.zf;
      neg_flag  = s.nf;
      opcode    = s.op;
      #1;
      check(tag, e);
      cyc++;
    end
  endtask

  // ---------------- directed + random sequence ----------------
  initial begin
    reset_n   = 1'b0;
    mem_ready = 1'b1;
    @(posedge clock);
    @(negedge clock);
    #1;
    check("reset_state", pk(0,0,0,1,0,0,0,0,2'b00,0,0,3'd0));
    @(negedge clock);
    opcode = 5'd3;
    #1;
    check("reset_hold", pk(0,0,0,1,0,0,0,0,2'b00,0,0,3'd0));

    add_instr(5'd3, 0, 0, 1'b0, 1'b0, -1);             run_queue("ldi5");
    add_instr(5'd4, 0, 2, 1'b0, 1'b0, -1);             run_queue("add9_stall");
    add_instr(5'd8, 0, 0, 1'b1, 1'b0, -1);             run_queue("beq_taken");
    add_instr(5'd8, 0, 0, 1'b0, 1'b0, -1);             run_queue("beq_not_taken");
    add_instr(5'd1, 0, 0, 1'b0, 1'b0, -1);             run_queue("sto3");
    add_instr(5'd0, 0, 10, 1'b0, 1'b0, -1);            run_queue("hlt_reset");
    add_instr(5'd4, 0, 3, 1'b0, 1'b0, 4);              run_queue("reset_in_memrd");
    add_instr(5'd1, 1, 3, 1'b0, 1'b0, 4);              run_queue("reset_in_store");
    add_instr(5'd3, 0, 0, 1'b0, 1'b0, 2);              run_queue("reset_in_exec");
    add_instr(5'd12, 0, 0, 1'b0, 1'b0, -1);            run_queue("clr");
    add_instr(5'd12, 0, 0, 1'b0, 1'b0, 2);             run_queue("reset_in_clr");
    add_instr(5'd20, 2, 0, 1'b0, 1'b0, 2);             run_queue("reset_in_fetch_ready");
    add_instr(5'd20, 0, 0, 1'b0, 1'b0, -1);            run_queue("nop");
    add_instr(5'd10, 0, 0, 1'b0, 1'b1, -1);            run_queue("blt_taken");
    add_instr(5'd9, 0, 0, 1'b1, 1'b0, -1);             run_queue("bne_not_taken");
    add_instr(5'd11, 0, 0, 1'b1, 1'b1, -1);            run_queue("jmp");

    for (int n = 0; n < 300; n++) begin
      logic [4:0] op;
      int         rat;
      op  = 5'($urandom_range(0, 31));
      rat = ($urandom_range(0, 9) == 0) ? int'($urandom_range(0, 5)) : -1;
      add_instr(op, int'($urandom_range(0, 3)), int'($urandom_range(0, 3)),
                1'($urandom_range(0, 1)), 1'($urandom_range(0, 1)), rat);
      run_queue("random");
    end

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule
